// File: rtl/seven_seg_display_arbiter.sv
// Seven-segment display arbiter: grants the 4-digit display to one of three
// content sources by fixed priority with a minimum hold time, and cross-fades
// between owners by ramping brightness down, swapping content, then ramping up.
module seven_seg_display_arbiter #(
  parameter int TICK_DIV   = 1000000,
  parameter int HOLD_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [47:0] req_buf,
  input  logic [8:0]  req_dp,
  input  logic [3:0]  lum_target,
  output logic [2:0]  grant,
  output logic [15:0] disp_buf,
  output logic [2:0]  dp,
  output logic [3:0]  lum,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    FADE_IN,
    SHOW,
    FADE_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    holdCnt_q, holdCnt_d;
  logic [2:0]    grant_q, grant_d;
  logic [15:0]   dispBuf_q, dispBuf_d;
  logic [2:0]    dp_q, dp_d;
  logic [3:0]    lum_q, lum_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic [2:0]    winner;
  logic          ownerReq;
  logic          higherReq;
  logic          holdDone;
  logic          releaseOwner;

  // Digit data slice belonging to a one-hot source select.
  function automatic logic [15:0] selBuf(input logic [2:0] sel, input logic [47:0] bufs);
    case (sel)
      3'b001:  selBuf = bufs[15:0];
      3'b010:  selBuf = bufs[31:16];
      3'b100:  selBuf = bufs[47:32];
      default: selBuf = 16'h0000;
    endcase
  endfunction

  // Decimal-point slice belonging to a one-hot source select.
  function automatic logic [2:0] selDp(input logic [2:0] sel, input logic [8:0] dps);
    case (sel)
      3'b001:  selDp = dps[2:0];
      3'b010:  selDp = dps[5:3];
      3'b100:  selDp = dps[8:6];
      default: selDp = 3'b000;
    endcase
  endfunction

  // Free-running prescaler; tick marks the cycle whose edge wraps it to 0.
  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Fixed-priority winner (lowest index) and owner release/preemption terms.
  always_comb begin
    winner = 3'b000;
    if (req[0])      winner = 3'b001;
    else if (req[1]) winner = 3'b010;
    else if (req[2]) winner = 3'b100;
    ownerReq     = |(req & grant_q);
    higherReq    = |(req & (grant_q - 3'd1));
    holdDone     = (holdCnt_q == 8'(HOLD_TICKS));
    releaseOwner = !ownerReq || (higherReq && holdDone);
  end

  // Next-state and registered-output logic for the fade/swap sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    dispBuf_d = dispBuf_q;
    dp_d      = dp_q;
    lum_d     = lum_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      IDLE: begin
        grant_d   = 3'b000;
        dispBuf_d = 16'h0000;
        dp_d      = 3'b000;
        lum_d     = 4'd0;
        if (|req) state_d = SWAP;
      end
      SWAP: begin
        lum_d     = 4'd0;
        holdCnt_d = 8'd0;
        if (|req) begin
          grant_d   = winner;
          dispBuf_d = selBuf(winner, req_buf);
          dp_d      = selDp(winner, req_dp);
          state_d   = FADE_IN;
        end else begin
          grant_d   = 3'b000;
          dispBuf_d = 16'h0000;
          dp_d      = 3'b000;
          state_d   = IDLE;
        end
      end
      FADE_IN: begin
        if (tick && !holdDone) holdCnt_d = holdCnt_q + 8'd1;
        if (releaseOwner) begin
          grant_d = 3'b000;
          state_d = FADE_OUT;
        end else if (lum_q == lum_target) begin
          state_d = SHOW;
        end else if (lum_q > lum_target) begin
          lum_d = lum_target;
        end else if (tick) begin
          lum_d = lum_q + 4'd1;
        end
      end
      SHOW: begin
        if (tick && !holdDone) holdCnt_d = holdCnt_q + 8'd1;
        if (releaseOwner) begin
          grant_d = 3'b000;
          state_d = FADE_OUT;
        end else begin
          dispBuf_d = selBuf(grant_q, req_buf);
          dp_d      = selDp(grant_q, req_dp);
          lum_d     = lum_target;
        end
      end
      FADE_OUT: begin
        if (lum_q == 4'd0) state_d = SWAP;
        else if (tick)     lum_d   = lum_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FADE_OUT) || (state_d == SWAP) || (state_d == FADE_IN);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      holdCnt_q <= 8'd0;
      grant_q   <= 3'b000;
      dispBuf_q <= 16'h0000;
      dp_q      <= 3'b000;
      lum_q     <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      holdCnt_q <= holdCnt_d;
      grant_q   <= grant_d;
      dispBuf_q <= dispBuf_d;
      dp_q      <= dp_d;
      lum_q     <= lum_d;
      busy_q    <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign disp_buf = dispBuf_q;
  assign dp       = dp_q;
  assign lum      = lum_q;
  assign busy     = busy_q;

endmodule
